test_mem_responder: RTL and testbench

- Memory-side end of the processor's instruction/data memory request/response interface: accepts val/rdy memory requests, performs word reads/writes on an internal array, and returns responses carrying the requester's opaque tag.
- Programmable minimum intervals between accepted requests and between issued responses, so processor test suites can sweep memory back-pressure and latency.
- Instantiated by the processor test harnesses; synthesizable style, no delays.

---
 rtl/mem_msg_pkg.sv | 38 +++
 rtl/resp_fifo.sv | 56 +++++
 rtl/test_mem_responder.sv | 129 ++++++++++++
 tb/tb_test_mem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_msg_pkg.sv
// Purpose: shared memory request/response types for the processor test harnesses.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
// Contents: mem_op_t, default-width request/response structs, word index helper.
package mem_msg_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_t;

  // Default field widths used by harnesses that do not override the tag width.
  localparam int unsigned MEM_ADDR_BITS = 32;
  localparam int unsigned MEM_DATA_BITS = 32;
  localparam int unsigned MEM_OPAQ_BITS = 8;

  typedef struct packed {
    mem_op_t                  op;
    logic [MEM_OPAQ_BITS-1:0] opaque;
    logic [MEM_ADDR_BITS-1:0] addr;
    logic [MEM_DATA_BITS-1:0] data;
  } mem_req_t;

  typedef struct packed {
    mem_op_t                  op;
    logic [MEM_OPAQ_BITS-1:0] opaque;
    logic [MEM_ADDR_BITS-1:0] addr;
    logic [MEM_DATA_BITS-1:0] data;
  } mem_resp_t;

  // Byte address -> word index; the byte offset is dropped and the upper
  // bits wrap modulo the (power-of-two) array size.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned words);
    return (addr >> 2) & (words - 1);
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Purpose: circular response buffer, p_depth entries, valid/ready on both sides.
// Latency: 1 cycle enqueue-to-dequeue (registered storage, no bypass).
// Backpressure: enq_rdy_o only reflects current occupancy, never a same-cycle dequeue.
// Ports: clk_i/rst_n_i, enq_{val,rdy,dat}, deq_{val,rdy,dat}.
module resp_fifo #(
  parameter int unsigned p_depth = 2,
  parameter int unsigned p_width = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               enq_val_i,
  output logic               enq_rdy_o,
  input  logic [p_width-1:0] enq_dat_i,
  output logic               deq_val_o,
  input  logic               deq_rdy_i,
  output logic [p_width-1:0] deq_dat_o
);

  localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CNT_W = $clog2(p_depth + 1);

  logic [p_width-1:0] ent_q [p_depth];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               enq_fire, deq_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(p_depth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign enq_rdy_o = (count_q < CNT_W'(p_depth));
  assign deq_val_o = (count_q != '0);
  assign enq_fire  = enq_val_i && enq_rdy_o;
  assign deq_fire  = deq_val_o && deq_rdy_i;
  assign deq_dat_o = ent_q[head_q];

  // Entries are cleared on reset so the head reads as all-zero while empty
  // after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(p_depth); i++) ent_q[i] <= '0;
    end else begin
      if (enq_fire) begin
        ent_q[tail_q] <= enq_dat_i;
        tail_q        <= ptr_inc(tail_q);
      end
      if (deq_fire) head_q <= ptr_inc(head_q);
      if (enq_fire && !deq_fire)      count_q <= count_q + CNT_W'(1);
      else if (!enq_fire && deq_fire) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/test_mem_responder.sv
// Purpose: memory-side responder: word array, val/rdy requests, tagged responses.
// Latency: >= 1 cycle accept-to-resp_val; programmable accept and response spacing.
// Backpressure: req_rdy drops while the accept interval runs or the buffer is full.
// Ports: clk/rst, req_* (request in), resp_* (response out), ld_* (backdoor word load).
module test_mem_responder
  import mem_msg_pkg::*;
#(
  parameter int unsigned p_opaq_bits       = 8,
  parameter int unsigned p_mem_words       = 256,
  parameter int unsigned p_depth           = 2,
  parameter int unsigned p_recv_intv_delay = 1,
  parameter int unsigned p_send_intv_delay = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_opaq_bits-1:0] req_opaque,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_data,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [p_opaq_bits-1:0] resp_opaque,
  output logic [31:0]            resp_addr,
  output logic [31:0]            resp_data,
  input  logic                   ld_en,
  input  logic [31:0]            ld_addr,
  input  logic [31:0]            ld_data
);

  localparam int unsigned IDX_W  = (p_mem_words > 1) ? $clog2(p_mem_words) : 1;
  localparam int unsigned RCNT_W = $clog2(p_recv_intv_delay) + 1;
  localparam int unsigned SCNT_W = $clog2(p_send_intv_delay) + 1;

  if (p_recv_intv_delay < 1) begin : g_bad_recv
    $fatal(1, "test_mem_responder: p_recv_intv_delay must be >= 1");
  end
  if (p_send_intv_delay < 1) begin : g_bad_send
    $fatal(1, "test_mem_responder: p_send_intv_delay must be >= 1");
  end
  if (p_depth < 1) begin : g_bad_depth
    $fatal(1, "test_mem_responder: p_depth must be >= 1");
  end
  if ((p_mem_words < 1) || ((p_mem_words & (p_mem_words - 1)) != 0)) begin : g_bad_words
    $fatal(1, "test_mem_responder: p_mem_words must be a power of two");
  end

  typedef struct packed {
    mem_op_t                op;
    logic [p_opaq_bits-1:0] opaque;
    logic [31:0]            addr;
    logic [31:0]            data;
  } resp_t;

  logic [31:0]       mem [p_mem_words];
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [IDX_W-1:0]  req_idx, ld_idx;
  resp_t             enq_dat, deq_dat;
  logic              fifo_enq_rdy, fifo_deq_val;
  logic              req_fire, resp_fire;

  assign req_idx = IDX_W'(word_index(req_addr, p_mem_words));
  assign ld_idx  = IDX_W'(word_index(ld_addr, p_mem_words));

  // Gating with rst keeps req_rdy low for the whole reset window, since the
  // cleared counters alone would otherwise advertise ready.
  assign req_rdy   = rst && (rcnt_q == '0) && fifo_enq_rdy;
  assign req_fire  = req_val && req_rdy;
  assign resp_val  = fifo_deq_val && (scnt_q == '0);
  assign resp_fire = resp_val && resp_rdy;

  // Read data is sampled combinationally in the accept cycle; a write from the
  // previous edge is already visible, which keeps write-then-read ordered.
  always_comb begin
    enq_dat        = '0;
    enq_dat.op     = mem_op_t'(req_op);
    enq_dat.opaque = req_opaque;
    enq_dat.addr   = req_addr;
    enq_dat.data   = req_op ? 32'h0 : mem[req_idx];
  end

  // The request write is issued last so it overrides a same-word backdoor load.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    if (req_fire && req_op) mem[req_idx] <= req_data;
  end

  always_comb begin
    rcnt_d = rcnt_q;
    if (req_fire)            rcnt_d = RCNT_W'(p_recv_intv_delay - 1);
    else if (rcnt_q != '0)   rcnt_d = rcnt_q - RCNT_W'(1);
    scnt_d = scnt_q;
    if (resp_fire)           scnt_d = SCNT_W'(p_send_intv_delay - 1);
    else if (scnt_q != '0)   scnt_d = scnt_q - SCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      scnt_q <= scnt_d;
    end
  end

  resp_fifo #(
    .p_depth (p_depth),
    .p_width ($bits(resp_t))
  ) u_resp_fifo (
    .clk_i     (clk),
    .rst_n_i   (rst),
    .enq_val_i (req_fire),
    .enq_rdy_o (fifo_enq_rdy),
    .enq_dat_i (enq_dat),
    .deq_val_o (fifo_deq_val),
    .deq_rdy_i (resp_rdy && (scnt_q == '0)),
    .deq_dat_o (deq_dat)
  );

  assign resp_op     = deq_dat.op;
  assign resp_opaque = deq_dat.opaque;
  assign resp_addr   = deq_dat.addr;
  assign resp_data   = deq_dat.data;

endmodule

// File: tb/tb_test_mem_responder.sv
// Purpose: directed bench for test_mem_responder (default, slow-accept, slow-send instances).
// Latency: n/a.
// Backpressure: resp_rdy driven per step.
module tb_test_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a: defaults, b: accept interval 3, c: response interval 3
  logic        a_req_val, a_req_rdy, a_req_op, a_resp_val, a_resp_rdy, a_resp_op, a_ld_en;
  logic [7:0]  a_req_opaque, a_resp_opaque;
  logic [31:0] a_req_addr, a_req_data, a_resp_addr, a_resp_data, a_ld_addr, a_ld_data;
  logic        b_req_val, b_req_rdy, b_req_op, b_resp_val, b_resp_rdy, b_resp_op, b_ld_en;
  logic [7:0]  b_req_opaque, b_resp_opaque;
  logic [31:0] b_req_addr, b_req_data, b_resp_addr, b_resp_data, b_ld_addr, b_ld_data;
  logic        c_req_val, c_req_rdy, c_req_op, c_resp_val, c_resp_rdy, c_resp_op, c_ld_en;
  logic [7:0]  c_req_opaque, c_resp_opaque;
  logic [31:0] c_req_addr, c_req_data, c_resp_addr, c_resp_data, c_ld_addr, c_ld_data;

  test_mem_responder u_a (
    .clk(clk), .rst(rst), .req_val(a_req_val), .req_rdy(a_req_rdy), .req_op(a_req_op),
    .req_opaque(a_req_opaque), .req_addr(a_req_addr), .req_data(a_req_data),
    .resp_val(a_resp_val), .resp_rdy(a_resp_rdy), .resp_op(a_resp_op),
    .resp_opaque(a_resp_opaque), .resp_addr(a_resp_addr), .resp_data(a_resp_data),
    .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data)
  );

  test_mem_responder #(.p_recv_intv_delay(3)) u_b (
    .clk(clk), .rst(rst), .req_val(b_req_val), .req_rdy(b_req_rdy), .req_op(b_req_op),
    .req_opaque(b_req_opaque), .req_addr(b_req_addr), .req_data(b_req_data),
    .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_op(b_resp_op),
    .resp_opaque(b_resp_opaque), .resp_addr(b_resp_addr), .resp_data(b_resp_data),
    .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
  );

  test_mem_responder #(.p_send_intv_delay(3)) u_c (
    .clk(clk), .rst(rst), .req_val(c_req_val), .req_rdy(c_req_rdy), .req_op(c_req_op),
    .req_opaque(c_req_opaque), .req_addr(c_req_addr), .req_data(c_req_data),
    .resp_val(c_resp_val), .resp_rdy(c_resp_rdy), .resp_op(c_resp_op),
    .resp_opaque(c_resp_opaque), .resp_addr(c_resp_addr), .resp_data(c_resp_data),
    .ld_en(c_ld_en), .ld_addr(c_ld_addr), .ld_data(c_ld_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_acc;
    int last_acc;
    int n_hs;
    int hs_cyc [3];
    logic [31:0] hs_dat [3];

    rst = 1'b0;
    {a_req_val, a_req_op, a_resp_rdy, a_ld_en} = '0;
    {b_req_val, b_req_op, b_resp_rdy, b_ld_en} = '0;
    {c_req_val, c_req_op, c_resp_rdy, c_ld_en} = '0;
    {a_req_opaque, a_req_addr, a_req_data, a_ld_addr, a_ld_data} = '0;
    {b_req_opaque, b_req_addr, b_req_data, b_ld_addr, b_ld_data} = '0;
    {c_req_opaque, c_req_addr, c_req_data, c_ld_addr, c_ld_data} = '0;
    b_req_val  = 1'b1;
    b_resp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin hs_cyc[i] = 0; hs_dat[i] = '0; end

    // Reset state
    #2;
    chk("rst_req_rdy", a_req_rdy, 0);
    chk("rst_resp_val", a_resp_val, 0);
    chk("rst_resp_opaque", a_resp_opaque, 0);
    chk("rst_resp_addr", a_resp_addr, 0);
    chk("rst_resp_data", a_resp_data, 0);
    chk("rst_req_rdy_held_val", b_req_rdy, 0);
    tick();
    tick();
    rst = 1'b1;

    // Accept interval 3 with req_val held: accepts at cycles 0,3,6,9
    n_acc = 0;
    last_acc = -1;
    for (int k = 0; k < 12; k++) begin
      b_req_val  = (n_acc < 4);
      b_req_addr = 32'(n_acc * 4);
      #1;
      chk($sformatf("t2_rdy_cyc%0d", k), b_req_rdy, (k % 3 == 0));
      if (b_req_val && b_req_rdy) begin n_acc++; last_acc = k; end
      tick();
    end
    b_req_val = 1'b0;
    chk("t2_accepts", n_acc, 4);
    chk("t2_last_accept_cyc", last_acc, 9);

    // Response interval 3: preload then three back-to-back reads
    c_resp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_ld_en   = 1'b1;
      c_ld_addr = 32'h10 + 32'(4 * i);
      c_ld_data = 32'h11 * 32'(i + 1);
      tick();
    end
    c_ld_en = 1'b0;
    n_acc = 0;
    n_hs = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      c_req_val  = (n_acc < 3);
      c_req_op   = 1'b0;
      c_req_addr = 32'h10 + 32'(4 * n_acc);
      #1;
      if (c_resp_val && n_hs < 3) begin
        hs_cyc[n_hs] = cyc;
        hs_dat[n_hs] = c_resp_data;
        n_hs++;
      end
      if (c_req_val && c_req_rdy) n_acc++;
      tick();
    end
    c_req_val = 1'b0;
    chk("t3_handshakes", n_hs, 3);
    chk("t3_gap01", hs_cyc[1] - hs_cyc[0], 3);
    chk("t3_gap12", hs_cyc[2] - hs_cyc[1], 3);
    chk("t3_data0", hs_dat[0], 32'h11);
    chk("t3_data1", hs_dat[1], 32'h22);
    chk("t3_data2", hs_dat[2], 32'h33);

    // Write then read of the same word, resp_rdy=1
    a_resp_rdy   = 1'b1;
    a_req_val    = 1'b1;
    a_req_op     = 1'b1;
    a_req_opaque = 8'd3;
    a_req_addr   = 32'h100;
    a_req_data   = 32'hDEADBEEF;
    #1;
    chk("t1_wr_rdy", a_req_rdy, 1);
    chk("t1_no_comb_resp", a_resp_val, 0);
    tick();
    a_req_op     = 1'b0;
    a_req_opaque = 8'd4;
    #1;
    chk("t1_rd_rdy", a_req_rdy, 1);
    chk("t1_wr_resp_val", a_resp_val, 1);
    chk("t1_wr_resp_op", a_resp_op, 1);
    chk("t1_wr_resp_opaque", a_resp_opaque, 3);
    chk("t1_wr_resp_addr", a_resp_addr, 32'h100);
    chk("t1_wr_resp_data", a_resp_data, 0);
    tick();
    a_req_val = 1'b0;
    #1;
    chk("t1_rd_resp_val", a_resp_val, 1);
    chk("t1_rd_resp_op", a_resp_op, 0);
    chk("t1_rd_resp_opaque", a_resp_opaque, 4);
    chk("t1_rd_resp_data", a_resp_data, 32'hDEADBEEF);
    tick();
    chk("t1_drained", a_resp_val, 0);

    // Index wrap (0x400 -> word 0), with a colliding backdoor load that must lose
    a_req_val    = 1'b1;
    a_req_op     = 1'b1;
    a_req_opaque = 8'd5;
    a_req_addr   = 32'h400;
    a_req_data   = 32'h5;
    a_ld_en      = 1'b1;
    a_ld_addr    = 32'h0;
    a_ld_data    = 32'h99;
    tick();
    a_ld_en      = 1'b0;
    a_req_op     = 1'b0;
    a_req_opaque = 8'd6;
    a_req_addr   = 32'h0;
    tick();
    a_req_val = 1'b0;
    #1;
    chk("t5_resp_val", a_resp_val, 1);
    chk("t5_resp_opaque", a_resp_opaque, 6);
    chk("t5_wrap_data", a_resp_data, 32'h5);
    tick();

    // Full buffer with resp_rdy=0, then a single dequeue
    a_resp_rdy   = 1'b0;
    a_req_val    = 1'b1;
    a_req_op     = 1'b0;
    a_req_addr   = 32'h100;
    a_req_opaque = 8'd10;
    #1;
    chk("t4_rdy_k0", a_req_rdy, 1);
    tick();
    a_req_addr   = 32'h0;
    a_req_opaque = 8'd11;
    #1;
    chk("t4_rdy_k1", a_req_rdy, 1);
    chk("t4_val_k1", a_resp_val, 1);
    chk("t4_head_k1", a_resp_opaque, 10);
    tick();
    a_req_addr   = 32'h100;
    a_req_opaque = 8'd12;
    #1;
    chk("t4_full_rdy_k2", a_req_rdy, 0);
    chk("t4_head_k2", a_resp_opaque, 10);
    chk("t4_head_data_k2", a_resp_data, 32'hDEADBEEF);
    tick();
    chk("t4_full_rdy_k3", a_req_rdy, 0);
    chk("t4_head_stable_k3", a_resp_opaque, 10);
    a_resp_rdy = 1'b1;
    #1;
    chk("t4_no_bypass", a_req_rdy, 0);
    tick();
    a_resp_rdy = 1'b0;
    #1;
    chk("t4_rdy_after_deq", a_req_rdy, 1);
    chk("t4_head_k4", a_resp_opaque, 11);
    chk("t4_head_data_k4", a_resp_data, 32'h5);
    tick();
    a_req_val = 1'b0;
    #1;
    chk("t4_full_again", a_req_rdy, 0);
    chk("t6_pre_val", a_resp_val, 1);

    // Asynchronous reset with two responses buffered
    rst = 1'b0;
    #1;
    chk("t6_val_async", a_resp_val, 0);
    chk("t6_rdy_async", a_req_rdy, 0);
    chk("t6_opaque_async", a_resp_opaque, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_no_stale", a_resp_val, 0);
    chk("t6_rdy_release", a_req_rdy, 1);
    a_resp_rdy   = 1'b1;
    a_req_val    = 1'b1;
    a_req_op     = 1'b0;
    a_req_addr   = 32'h100;
    a_req_opaque = 8'd7;
    tick();
    a_req_val = 1'b0;
    #1;
    chk("t6_rd_val", a_resp_val, 1);
    chk("t6_rd_opaque", a_resp_opaque, 7);
    chk("t6_mem_kept", a_resp_data, 32'hDEADBEEF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
